// File: rtl/tick_rate_arbiter_if.sv
// rtl/tick_rate_arbiter_if.sv - request/grant/tick bundle between pacing engines and the shared divider
interface tick_rate_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] div_req;
    logic [NREQ-1:0]       grant;
    logic [OW-1:0]         owner;
    logic                  busy;
    logic                  tick;
    logic                  done;

    modport master (
        output req,
        output div_req,
        input  grant,
        input  owner,
        input  busy,
        input  tick,
        input  done
    );

    modport slave (
        input  req,
        input  div_req,
        output grant,
        output owner,
        output busy,
        output tick,
        output done
    );
endinterface

// File: rtl/tick_rate_arbiter.sv
// rtl/tick_rate_arbiter.sv - shared tick divider with arbitration; TICK_ARB_FIXED_PRIO_EN selects fixed priority
module tick_rate_arbiter #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 32,
    parameter int HOLD_TICKS = 8
) (
    input  logic               clk_in,
    input  logic               rst,
    tick_rate_arbiter_if.slave bus
);
    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(HOLD_TICKS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             busy_q,  busy_d;
    logic             tick_q,  tick_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q,   div_d;
    logic [TW-1:0]    left_q,  left_d;
`ifndef TICK_ARB_FIXED_PRIO_EN
    logic [OW-1:0]    ptr_q,   ptr_d;
`endif

    logic             found;
    logic [OW-1:0]    winner;
    logic [WIDTH-1:0] win_div;

    // Winner search over the live request vector
`ifdef TICK_ARB_FIXED_PRIO_EN
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                found  = 1'b1;
                winner = OW'(i);
            end
        end
    end
`else
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end
`endif

    // Divisor of the candidate winner; zero is promoted to one so the counter compare is always reachable
    always_comb begin
        win_div = bus.div_req[int'(winner) * WIDTH +: WIDTH];
        if (win_div == '0) begin
            win_div = WIDTH'(1);
        end
    end

    // Next-state and next-output logic for the IDLE/RUN controller
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        count_d = count_q;
        div_d   = div_q;
        left_d  = left_q;
`ifndef TICK_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    grant_d = NREQ'(1) << winner;
                    owner_d = winner;
                    busy_d  = 1'b1;
                    count_d = '0;
                    div_d   = win_div;
                    left_d  = TW'(HOLD_TICKS);
`ifndef TICK_ARB_FIXED_PRIO_EN
                    ptr_d   = winner;
`endif
                end
            end
            RUN: begin
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else if (count_q == div_q - WIDTH'(1)) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    left_d  = left_q - TW'(1);
                    if (left_q == TW'(1)) begin
                        state_d = IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State and output registers; async reset leaves the round-robin pointer so req[0] wins first
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            div_q   <= WIDTH'(1);
            left_q  <= '0;
`ifndef TICK_ARB_FIXED_PRIO_EN
            ptr_q   <= OW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            count_q <= count_d;
            div_q   <= div_d;
            left_q  <= left_d;
`ifndef TICK_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.grant = grant_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;
    assign bus.tick  = tick_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_tick_rate_arbiter.sv
// tb/tb_tick_rate_arbiter.sv - randomized and directed check of tick_rate_arbiter against a burst-schedule model
module tb_tick_rate_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int HOLD  = 3;

    logic clk_in = 1'b0;
    logic rst;

    tick_rate_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    tick_rate_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_TICKS(HOLD)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int passed = 0;

    // Model: a burst granted at edge e0 with divisor d ticks at edges e0 + k*d, k = 1..HOLD
    longint    n = 0;
    logic      m_busy;
    logic [3:0] m_grant;
    int        m_owner;
    logic      m_tick;
    logic      m_done;
    int        m_ptr;
    longint    m_e0;
    longint    m_div;
    longint    tick_q[$];
    longint    done_q[$];
    longint    grant_edge_q[$];
    int        grant_val_q[$];

    function automatic longint div_of(input int i);
        logic [WIDTH-1:0] v;
        v = bus.div_req[i*WIDTH +: WIDTH];
        return (v == 0) ? 64'd1 : longint'(v);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_grant = 0; m_owner = 0; m_tick = 0; m_done = 0;
        m_ptr = NREQ - 1; m_e0 = 0; m_div = 1;
    endtask

    task automatic model_edge();
        int w;
        bit f;
        m_tick = 0;
        m_done = 0;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            if (!bus.req[m_owner]) begin
                m_busy = 0;
                m_grant = 0;
            end else if ((n - m_e0) % m_div == 0) begin
                m_tick = 1;
                tick_q.push_back(n);
                if ((n - m_e0) / m_div == HOLD) begin
                    m_done = 1; m_busy = 0; m_grant = 0;
                    done_q.push_back(n);
                end
            end
        end else if (bus.req != 0) begin
            f = 0; w = 0;
`ifdef TICK_ARB_FIXED_PRIO_EN
            for (int i = 0; i < NREQ; i++) if (!f && bus.req[i]) begin f = 1; w = i; end
`else
            for (int i = 1; i <= NREQ; i++) begin
                if (!f && bus.req[(m_ptr + i) % NREQ]) begin f = 1; w = (m_ptr + i) % NREQ; end
            end
            m_ptr = w;
`endif
            m_owner = w;
            m_grant = 4'(1 << w);
            m_busy  = 1;
            m_e0    = n;
            m_div   = div_of(w);
            grant_edge_q.push_back(n);
            grant_val_q.push_back(int'(m_grant));
        end
    endtask

    task automatic compare(input string tag);
        checks++;
        if (bus.grant !== m_grant || bus.owner !== 2'(m_owner) || bus.busy !== m_busy ||
            bus.tick !== m_tick || bus.done !== m_done) begin
            $display("FAIL %s edge %0d: got grant=%b owner=%0d busy=%b tick=%b done=%b, want grant=%b owner=%0d busy=%b tick=%b done=%b",
                     tag, n, bus.grant, bus.owner, bus.busy, bus.tick, bus.done,
                     m_grant, m_owner, m_busy, m_tick, m_done);
        end else begin
            passed++;
        end
    endtask

    task automatic check_val(input string tag, input longint got, input longint want);
        checks++;
        if (got !== want) $display("FAIL %s: got %0d, want %0d", tag, got, want);
        else passed++;
    endtask

    // One clock: model steps on the edge, outputs compared 1 time unit later, returns at the negedge
    task automatic cycle(input string tag);
        @(posedge clk_in);
        n++;
        model_edge();
        #1;
        compare(tag);
        @(negedge clk_in);
    endtask

    task automatic run(input string tag, input int k);
        for (int i = 0; i < k; i++) cycle(tag);
    endtask

    task automatic set_div(input int i, input int v);
        bus.div_req[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic clear_logs();
        tick_q.delete(); done_q.delete(); grant_edge_q.delete(); grant_val_q.delete();
    endtask

    task automatic do_reset();
        bus.req = 0;
        rst = 1;
        run("reset", 3);
        rst = 0;
        run("post_reset", 2);
        clear_logs();
    endtask

    longint e0;
    int     ticks_seen;

    initial begin
        rst = 1;
        bus.req = 0;
        bus.div_req = '0;
        model_reset();
        @(negedge clk_in);

        // Reset and long idle: nothing may move
        do_reset();
        ticks_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle("idle");
            if (bus.tick) ticks_seen++;
        end
        check_val("idle_no_tick", ticks_seen, 0);
        check_val("idle_grant", bus.grant, 0);

        // Single burst, divisor 5
        set_div(1, 5);
        bus.req = 4'b0010;
        cycle("single");
        e0 = n;
        check_val("single_grant", bus.grant, 4'b0010);
        run("single", 15);
        bus.req = 0;
        check_val("single_ticks_n", tick_q.size(), 3);
        if (tick_q.size() == 3) begin
            check_val("single_tick1", tick_q[0], e0 + 5);
            check_val("single_tick2", tick_q[1], e0 + 10);
            check_val("single_tick3", tick_q[2], e0 + 15);
        end
        check_val("single_done", (done_q.size() == 1) ? done_q[0] : -1, e0 + 15);
        check_val("single_release", bus.grant, 0);
        run("single_tail", 3);

        // Arbitration order with three requesters held high
        do_reset();
        for (int i = 0; i < NREQ; i++) set_div(i, 2);
        bus.req = 4'b1011;
        run("rr", 28);
        bus.req = 0;
        run("rr_tail", 8);
        check_val("rr_n", (grant_val_q.size() >= 4) ? 1 : 0, 1);
        if (grant_val_q.size() >= 4) begin
`ifdef TICK_ARB_FIXED_PRIO_EN
            check_val("prio_g0", grant_val_q[0], 1);
            check_val("prio_g1", grant_val_q[1], 1);
            check_val("prio_g2", grant_val_q[2], 1);
            check_val("prio_g3", grant_val_q[3], 1);
`else
            check_val("rr_g0", grant_val_q[0], 1);
            check_val("rr_g1", grant_val_q[1], 2);
            check_val("rr_g2", grant_val_q[2], 8);
            check_val("rr_g3", grant_val_q[3], 1);
`endif
            check_val("rr_gap", grant_edge_q[1] - grant_edge_q[0], 7);
        end

        // Divisor 0 and 1: back-to-back ticks
        for (int v = 0; v < 2; v++) begin
            do_reset();
            set_div(0, v);
            bus.req = 4'b0001;
            cycle("div_small");
            e0 = n;
            run("div_small", 3);
            bus.req = 0;
            check_val("div_small_ticks", tick_q.size(), 3);
            if (tick_q.size() == 3) check_val("div_small_last", tick_q[2], e0 + 3);
            check_val("div_small_done", (done_q.size() == 1) ? done_q[0] : -1, e0 + 3);
            run("div_small_tail", 2);
        end

        // Divisor change mid-burst is ignored
        do_reset();
        set_div(2, 3);
        bus.req = 4'b0100;
        cycle("div_chg");
        e0 = n;
        run("div_chg", 2);
        set_div(2, 7);
        run("div_chg", 7);
        bus.req = 0;
        check_val("div_chg_ticks", tick_q.size(), 3);
        if (tick_q.size() == 3) check_val("div_chg_last", tick_q[2], e0 + 9);
        run("div_chg_tail", 3);

        // Abort: owner drops two cycles before its 2nd tick
        do_reset();
        set_div(0, 4);
        set_div(1, 2);
        bus.req = 4'b0011;
        cycle("abort");
        e0 = n;
        run("abort", 5);
        bus.req = 4'b0010;
        cycle("abort");
        check_val("abort_busy", bus.busy, 0);
        cycle("abort");
        check_val("abort_regrant", bus.grant, 4'b0010);
        check_val("abort_ticks", tick_q.size(), 1);
        check_val("abort_no_done", done_q.size(), 0);
        bus.req = 0;
        run("abort_tail", 6);

        // Asynchronous reset between edges during a burst
        do_reset();
        set_div(0, 4);
        bus.req = 4'b0001;
        run("areset", 5);
        #2;
        rst = 1;
        bus.req = 4'b1100;
        #1;
        model_reset();
        compare("areset_imm");
        @(negedge clk_in);
        run("areset_hold", 2);
        rst = 0;
        clear_logs();
        cycle("areset_rel");
        check_val("areset_grant", bus.grant, 4'b0100);
        bus.req = 0;
        run("areset_tail", 20);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < NREQ; i++) set_div(i, $urandom_range(0, 6));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) bus.req[$urandom_range(0, NREQ-1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) set_div($urandom_range(0, NREQ-1), $urandom_range(0, 6));
            cycle("random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tick_rate_arbiter.md
# tick_rate_arbiter

Shares a single programmable tick divider among NREQ requesters, each asking for its own divide ratio. Round-robin arbitration grants the divider to one requester at a time. The divider is loaded with that requester's divisor and issues single-cycle enable ticks on the shared clk_in domain for a fixed burst of HOLD_TICKS ticks, then releases the divider. It sits between the per-engine pacing logic (LED/display scan, UART baud, NN layer step) and the datapath, replacing per-engine free-running dividers.

## Interface
- NREQ, 4: number of requesters, 2..16.
- WIDTH, 32: divisor and counter width.
- HOLD_TICKS, 8: ticks issued per grant, ≥1.
- clk_in  in  1  sole clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request level; hold high until done.
- div_req  in  NREQ*WIDTH  requester i divisor in bits [i*WIDTH +: WIDTH].
- grant  out  NREQ  one-hot owner of the divider; all-zero when idle.
- owner  out  $clog2(NREQ)  index of current or last owner.
- busy  out  1  high while in RUN.
- tick  out  1  one-cycle enable pulse, period = latched divisor.
- done  out  1  one-cycle pulse on completion of a burst.

## Operation
- Reset (async assert): state=IDLE; grant=0, owner=0, busy=0, tick=0, done=0, counter=0, ticks_left=0, rr pointer=NREQ-1 (req[0] wins first).
- Two states: IDLE, RUN.
- IDLE: if req≠0, pick the first set bit searching from pointer+1 upward with wrap. Latch div_l = div_req slice (0 treated as 1). Set counter=0, ticks_left=HOLD_TICKS, grant/owner/pointer = winner, busy=1, then go to RUN. If req=0, stay; tick=done=0.
- RUN, per edge, evaluated in priority order:
  - req[owner]=0 → abort: go to IDLE; grant=0, busy=0, tick=0, done=0, counter=0.
  - counter==div_l-1 → counter=0, tick=1, ticks_left-1. If ticks_left was 1, also go to IDLE with grant=0, busy=0, done=1.
  - else counter+1, tick=0.
- div_req changes during RUN are ignored. Other req bits changing during RUN are ignored until IDLE.
- Counter compares equality only. It never wraps past div_l-1, so div_l=2^WIDTH-1 is legal.
- owner holds its value after release.

## Timing
- All outputs are registered.
- Grant edge E0: req seen high in IDLE at E0 gives grant/busy high after E0.
- The k-th tick is high the cycle after edge E0+k*div_l. div_l=1 gives tick on every RUN cycle.
- The final tick, done, and the grant/busy fall are all visible in the same cycle.
- At least one IDLE cycle separates consecutive grants. Next grant edge = final-tick edge + 1.
- Abort takes effect on the edge where req[owner] is seen low. No tick or done is issued on that edge.
- rst mid-burst clears everything asynchronously. No done is issued. After release, arbitration restarts from req[0].

## Configuration
- TICK_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. The pointer is not used and not updated.
- Undefined (default): round-robin as described above.
- Interface and timing are identical in both builds.

## Test plan
- Reset/idle: rst high for 3 cycles, req=0 → all outputs 0; stays idle for 20 cycles, no tick.
- Single burst (HOLD_TICKS=3): req=4'b0010, div_req[1]=5 → grant=0010 one cycle later; ticks at grant+5, +10, +15; done coincides with the 3rd tick; grant falls the same cycle.
- Round-robin: req=4'b1011 held, div=2 for all → grant sequence 0001, 0010, 1000, 0001, each separated by one idle cycle. With TICK_ARB_FIXED_PRIO_EN → 0001 repeatedly.
- Divisor edge cases: div_req=0 and 1 → tick every RUN cycle, HOLD_TICKS ticks back-to-back. div_req=3 changed to 7 mid-burst → period stays 3.
- Abort: owner drops req two cycles before the 2nd tick → no further tick, no done, busy=0 next cycle; the other pending requester is granted one cycle later.
- Async reset mid-burst: assert rst between edges during RUN → grant/busy/tick go 0 immediately. After release with req=4'b1100 → grant=0100.
